// File: rtl/div_unit_pkg.sv
// Shared constants for the multi-cycle restoring divider: FSM encodings,
// ready flag values and the default iteration count.
package div_unit_pkg;

    localparam logic [1:0] DIV_FREE   = 2'b00;
    localparam logic [1:0] DIV_BYZERO = 2'b01;
    localparam logic [1:0] DIV_ON     = 2'b10;
    localparam logic [1:0] DIV_END    = 2'b11;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam int DIV_CYCLES = 32;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left by one and
// subtract the divisor from the widened remainder if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    // The shifted remainder needs WIDTH+1 bits: the bit leaving rem's MSB
    // still counts towards the comparison against the divisor.
    logic [WIDTH:0] w_rem_shifted;
    logic [WIDTH:0] w_trial;

    assign w_rem_shifted = {i_rem, i_quo[WIDTH-1]};
    assign w_trial       = w_rem_shifted - {1'b0, i_div};

    always_comb begin
        o_rem = w_rem_shifted[WIDTH-1:0];
        o_quo = {i_quo[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH]) begin
            o_rem = w_trial[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// EX-stage multi-cycle divider (DIV/DIVU): result is {remainder, quotient},
// with a combinational stall request while a division is outstanding.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stall_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_signed;
    logic [2*WIDTH-1:0] r_result;
    logic             r_ready;

    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_rem_final;
    logic [WIDTH-1:0] w_quo_final;
    logic             w_last_step;

    function automatic logic [WIDTH-1:0] abs_if(input logic [WIDTH-1:0] val,
                                                input logic             en);
        return (en && val[WIDTH-1]) ? (~val + 1'b1) : val;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] val,
                                                input logic             en);
        return en ? (~val + 1'b1) : val;
    endfunction

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_next),
        .o_quo (w_quo_next)
    );

    // Sign fix-up works on the final step's output so the result registers
    // on the same edge as the last iteration.
    assign w_quo_final = neg_if(w_quo_next, r_signed && (r_sign_a ^ r_sign_b));
    assign w_rem_final = neg_if(w_rem_next, r_signed && r_sign_a);
    assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= DIV_FREE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_signed <= 1'b0;
            r_result <= '0;
            r_ready  <= DIV_RESULT_NOT_READY;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    r_ready  <= DIV_RESULT_NOT_READY;
                    r_result <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            r_state <= DIV_BYZERO;
                        end else begin
                            r_quo    <= abs_if(opdata1_i, signed_i);
                            r_div    <= abs_if(opdata2_i, signed_i);
                            r_rem    <= '0;
                            r_sign_a <= opdata1_i[WIDTH-1];
                            r_sign_b <= opdata2_i[WIDTH-1];
                            r_signed <= signed_i;
                            r_cnt    <= '0;
                            r_state  <= DIV_ON;
                        end
                    end
                end
                DIV_BYZERO: begin
                    r_result <= '0;
                    r_ready  <= DIV_RESULT_READY;
                    r_state  <= DIV_END;
                end
                DIV_ON: begin
                    if (annul_i) begin
                        r_state <= DIV_FREE;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= '0;
                        r_div   <= '0;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last_step) begin
                            r_result <= {w_rem_final, w_quo_final};
                            r_ready  <= DIV_RESULT_READY;
                            r_state  <= DIV_END;
                        end
                    end
                end
                DIV_END: begin
                    // annul is deliberately ignored here: the result is committed.
                    if (!start_i) begin
                        r_state  <= DIV_FREE;
                        r_ready  <= DIV_RESULT_NOT_READY;
                        r_result <= '0;
                    end
                end
                default: begin
                    r_state <= DIV_FREE;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign stall_o  = start_i && !r_ready && !annul_i;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start_i = 1'b0;
    logic          annul_i = 1'b0;
    logic          signed_i = 1'b0;
    logic [W-1:0]  opdata1_i = '0;
    logic [W-1:0]  opdata2_i = '0;
    logic [2*W-1:0] result_o;
    logic          ready_o;
    logic          stall_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_unit #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .stall_o   (stall_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Truncating division as the ISA defines it; wide arithmetic absorbs
    // the -2^31 / -1 overflow, whose low 32 bits are the architected answer.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input string tag);
        logic [63:0] exp;
        int cyc;
        int stalls;
        exp = ref_div(a, b, s);
        @(negedge clk);
        annul_i   = 1'b0;
        start_i   = 1'b1;
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        #1;
        cyc = 0;
        stalls = 0;
        while (!ready_o && cyc < 100) begin
            if (stall_o) stalls++;
            @(posedge clk);
            #1;
            cyc++;
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_i  = 1'($urandom);
        end
        chk({tag, " latency"}, 64'(cyc), 64'((b == 32'd0) ? 2 : 33));
        chk({tag, " stall cycles"}, 64'(stalls), 64'((b == 32'd0) ? 2 : 33));
        chk({tag, " result"}, result_o, exp);
        chk({tag, " stall at ready"}, 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, " held result"}, result_o, exp);
        chk({tag, " held ready"}, 64'(ready_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " release ready"}, 64'(ready_o), 64'd0);
        chk({tag, " release result"}, result_o, 64'd0);
    endtask

    initial begin
        logic seen;
        logic [31:0] a, b;
        int k;

        #12;
        chk("reset result", result_o, 64'd0);
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_div(32'd100, 32'd7, 1'b1, "s100/7");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "s-7/2");
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "s7/-2");
        run_div(32'hFFFF_FFFF, 32'd2, 1'b0, "uFFFFFFFF/2");
        run_div(32'hFFFF_FFFF, 32'd2, 1'b1, "s-1/2");
        run_div(32'd5, 32'd0, 1'b1, "div0");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "smin/-1");
        run_div(32'd0, 32'd5, 1'b0, "u0/5");
        run_div(32'hDEAD_BEEF, 32'd1, 1'b0, "u/1");
        run_div(32'h1234_5678, 32'hFFFF_FFFF, 1'b0, "u/max");

        // Annul in the middle of an in-flight division
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1'b1;
        end
        @(negedge clk);
        annul_i = 1'b1;
        #1;
        chk("annul stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        if (ready_o) seen = 1'b1;
        chk("annul no ready", 64'(seen), 64'd0);
        run_div(32'd9, 32'd3, 1'b0, "after annul 9/3");

        // Start and annul together in FREE: nothing may start
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd20; opdata2_i = 32'd3;
        #1;
        chk("start+annul stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1'b1;
        end
        chk("start+annul no ready", 64'(seen), 64'd0);

        // Asynchronous reset while ON
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        repeat (15) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst mid-ON ready", 64'(ready_o), 64'd0);
        chk("rst mid-ON result", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run_div(32'd50, 32'd5, 1'b0, "after reset 50/5");

        // Asynchronous reset while a result is being held
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd4;
        k = 0;
        while (!ready_o && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("pre-reset END result", result_o, ref_div(32'd77, 32'd4, 1'b0));
        #2;
        resetn = 1'b0;
        #1;
        chk("rst END ready", 64'(ready_o), 64'd0);
        chk("rst END result", result_o, 64'd0);
        chk("rst END stall", 64'(stall_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 25; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 20);
                3:       b = -($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_div(a, b, 1'($urandom), $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
